// File: rtl/alu_exec_ctrl_pkg.sv
// Shared types and constants for the ALU execute controller.
package alu_exec_ctrl_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int NREGS_DEF  = 8;
    localparam int ADDR_W_DEF = $clog2(NREGS_DEF);

    // One instruction walks IDLE -> READ -> EXEC -> WB, one cycle each.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } exec_state_t;

    // Opcodes as encoded by the downstream ALU; forwarded untouched.
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SHR  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_NAND = 4'b1001;

    // True for opcodes the ALU defines; the controller forwards any code.
    function automatic logic op_is_defined(input logic [3:0] op);
        return op <= OP_NAND;
    endfunction

endpackage

// File: rtl/alu_exec_regfile.sv
// Register file for the execute controller: two combinational operand
// reads (latched by the controller in READ), one combinational debug read,
// and two write ports where the writeback port beats the direct load port.
module alu_exec_regfile
    import alu_exec_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wb_en,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_ld_en,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic [ADDR_W-1:0] i_rd_a_addr,
    output logic [DATA_W-1:0] o_rd_a_data,
    input  logic [ADDR_W-1:0] i_rd_b_addr,
    output logic [DATA_W-1:0] o_rd_b_data,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] r_mem [NREGS];

    // Storage update: load first, writeback last so writeback wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_ld_en) begin
                r_mem[i_ld_addr] <= i_ld_data;
            end
            if (i_wb_en) begin
                r_mem[i_wb_addr] <= i_wb_data;
            end
        end
    end

    // Combinational read ports.
    always_comb begin
        o_rd_a_data = r_mem[i_rd_a_addr];
        o_rd_b_data = r_mem[i_rd_b_addr];
        o_dbg_data  = r_mem[i_dbg_addr];
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller sitting upstream of an 8-bit ALU. Accepts
// one instruction per handshake, reads operands, drives the ALU, writes the
// result back and keeps a sticky zero flag.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both 1; instr_ready is 1 only in IDLE (and out of reset),
// and a source seeing ready=0 keeps its instruction stable until accepted.
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [1:0]        instr_sel,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    output logic [1:0]        alu_flag_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              done_valid,
    output logic [ADDR_W-1:0] done_rd,
    output logic [DATA_W-1:0] done_data,
    output logic              zero_flag,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic              r_rst_meta;
    logic              r_rst_sync;
    logic              w_rst_n;

    exec_state_t       r_state;
    logic [3:0]        r_op;
    logic [1:0]        r_sel;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic [ADDR_W-1:0] r_rd;
    logic              r_zero;

    logic [DATA_W-1:0] w_rd_a_data;
    logic [DATA_W-1:0] w_rd_b_data;
    logic              w_wb_en;

    // Reset synchronizer: assertion is immediate, release lines up with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    // Internal reset and handshake / writeback decodes of the state register.
    always_comb begin
        w_rst_n     = r_rst_sync;
        instr_ready = (r_state == ST_IDLE) && r_rst_sync;
        w_wb_en     = (r_state == ST_WB);
    end

    // Sequencer: IDLE -> READ -> EXEC -> WB -> IDLE with registered outputs.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_sel       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_zero      <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= '0;
            alu_flag_in <= '0;
            done_valid  <= 1'b0;
            done_rd     <= '0;
            done_data   <= '0;
            zero_flag   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        r_op    <= instr_op;
                        r_sel   <= instr_sel;
                        r_rs1   <= instr_rs1;
                        r_rs2   <= instr_rs2;
                        r_rd    <= instr_rd;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    alu_a       <= w_rd_a_data;
                    alu_b       <= w_rd_b_data;
                    alu_ctrl    <= r_op;
                    alu_flag_in <= r_sel;
                    r_state     <= ST_EXEC;
                end
                ST_EXEC: begin
                    // ALU has settled on the registered operands; capture it.
                    done_data  <= alu_result;
                    r_zero     <= alu_zero;
                    done_rd    <= r_rd;
                    done_valid <= 1'b1;
                    r_state    <= ST_WB;
                end
                ST_WB: begin
                    zero_flag  <= r_zero;
                    done_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    alu_exec_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk         (clk),
        .rst_n       (w_rst_n),
        .i_wb_en     (w_wb_en),
        .i_wb_addr   (r_rd),
        .i_wb_data   (done_data),
        .i_ld_en     (ld_en),
        .i_ld_addr   (ld_addr),
        .i_ld_data   (ld_data),
        .i_rd_a_addr (r_rs1),
        .o_rd_a_data (w_rd_a_data),
        .i_rd_b_addr (r_rs2),
        .o_rd_b_data (w_rd_b_data),
        .i_dbg_addr  (dbg_addr),
        .o_dbg_data  (dbg_data)
    );

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: a stand-in ALU, a reference register array and
// directed plus randomized instruction sequences.
module tb_alu_exec_ctrl;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [1:0] instr_sel;
    logic [2:0] instr_rs1;
    logic [2:0] instr_rs2;
    logic [2:0] instr_rd;
    logic       ld_en;
    logic [2:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_ctrl;
    logic [1:0] alu_flag_in;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       done_valid;
    logic [2:0] done_rd;
    logic [7:0] done_data;
    logic       zero_flag;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int         n_cmp;
    int         n_err;
    logic [7:0] ref_regs [8];
    logic       ref_zero;

    alu_exec_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_sel   (instr_sel),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .instr_rd    (instr_rd),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_flag_in (alu_flag_in),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .done_valid  (done_valid),
        .done_rd     (done_rd),
        .done_data   (done_data),
        .zero_flag   (zero_flag),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // ALU behaviour: sel[0] picks B instead of A for single-operand ops.
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [1:0] sel,
                                          input logic [7:0] a, input logic [7:0] b);
        logic [7:0] s;
        s = sel[0] ? b : a;
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return s >> 1;
            4'd4:    return a ^ b;
            4'd5:    return ~s;
            4'd6:    return a - b;
            4'd7:    return s << 1;
            4'd8:    return (a < b) ? 8'd1 : 8'd0;
            4'd9:    return ~(a & b);
            default: return 8'd0;
        endcase
    endfunction

    // Stand-in for the downstream combinational ALU.
    always_comb begin
        alu_result = alu_fn(alu_ctrl, alu_flag_in, alu_a, alu_b);
        alu_zero   = (alu_result == 8'd0);
    end

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [2:0] addr, input logic [7:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        tick();
        ld_en = 1'b0;
        ref_regs[addr] = data;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, {8'd0, dbg_data}, {8'd0, exp});
    endtask

    // ld_mode: 0 none, 1 load 0xAA to rd during WB, 2 load 0x55 to rs1 during READ.
    task automatic do_instr(input logic [3:0] op, input logic [1:0] sel,
                            input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                            input int ld_mode, output logic [7:0] got);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_res;
        a       = ref_regs[rs1];
        b       = ref_regs[rs2];
        exp_res = alu_fn(op, sel, a, b);
        check("ready_idle", {15'd0, instr_ready}, 16'd1);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_sel   = sel;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        instr_rd    = rd;
        tick();  // T+1
        instr_valid = 1'b0;
        instr_op    = 4'($urandom_range(0, 15));
        check("ready_busy", {15'd0, instr_ready}, 16'd0);
        check("done_t1", {15'd0, done_valid}, 16'd0);
        if (ld_mode == 2) begin
            ld_en   = 1'b1;
            ld_addr = rs1;
            ld_data = 8'h55;
        end
        tick();  // T+2
        ld_en = 1'b0;
        if (ld_mode == 2) ref_regs[rs1] = 8'h55;
        check("alu_a", {8'd0, alu_a}, {8'd0, a});
        check("alu_b", {8'd0, alu_b}, {8'd0, b});
        check("alu_ctrl", {12'd0, alu_ctrl}, {12'd0, op});
        check("alu_flag_in", {14'd0, alu_flag_in}, {14'd0, sel});
        check("done_t2", {15'd0, done_valid}, 16'd0);
        tick();  // T+3
        check("done_t3", {15'd0, done_valid}, 16'd1);
        check("done_rd", {13'd0, done_rd}, {13'd0, rd});
        check("done_data", {8'd0, done_data}, {8'd0, exp_res});
        check("alu_a_hold", {8'd0, alu_a}, {8'd0, a});
        got = done_data;
        if (ld_mode == 1) begin
            ld_en   = 1'b1;
            ld_addr = rd;
            ld_data = 8'hAA;
        end
        tick();  // T+4
        ld_en = 1'b0;
        ref_regs[rd] = exp_res;
        ref_zero     = (exp_res == 8'd0);
        check("done_t4", {15'd0, done_valid}, 16'd0);
        check("zero_flag", {15'd0, zero_flag}, {15'd0, ref_zero});
        check("ready_back", {15'd0, instr_ready}, 16'd1);
        check_reg("wb_reg", rd, exp_res);
    endtask

    initial begin
        logic [7:0] got;
        int         acc_q[$];
        logic [7:0] exp_r5;

        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = '0;
        instr_sel   = '0;
        instr_rs1   = '0;
        instr_rs2   = '0;
        instr_rd    = '0;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        dbg_addr    = '0;
        ref_zero    = 1'b0;
        for (int i = 0; i < 8; i++) ref_regs[i] = 8'd0;

        // Reset and reset state.
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("rst_ready", {15'd0, instr_ready}, 16'd1);
        check("rst_done_valid", {15'd0, done_valid}, 16'd0);
        check("rst_done_rd", {13'd0, done_rd}, 16'd0);
        check("rst_done_data", {8'd0, done_data}, 16'd0);
        check("rst_zero", {15'd0, zero_flag}, 16'd0);
        check("rst_alu_a", {8'd0, alu_a}, 16'd0);
        check("rst_alu_b", {8'd0, alu_b}, 16'd0);
        check("rst_alu_ctrl", {12'd0, alu_ctrl}, 16'd0);
        check("rst_alu_flag", {14'd0, alu_flag_in}, 16'd0);
        for (int i = 0; i < 8; i++) check_reg("rst_reg", 3'(i), 8'd0);

        // AND of disjoint nibbles gives zero.
        load(3'd1, 8'h0F);
        load(3'd2, 8'hF0);
        do_instr(4'b0000, 2'd0, 3'd1, 3'd2, 3'd3, 0, got);
        check("and_value", {8'd0, got}, 16'h0000);
        check("and_zero", {15'd0, zero_flag}, 16'd1);

        // ADD then SUB of a register from itself.
        do_instr(4'b0010, 2'd0, 3'd1, 3'd2, 3'd4, 0, got);
        check("add_value", {8'd0, got}, 16'h00FF);
        check("add_zero", {15'd0, zero_flag}, 16'd0);
        do_instr(4'b0110, 2'd0, 3'd4, 3'd4, 3'd4, 0, got);
        check("sub_value", {8'd0, got}, 16'h0000);
        check("sub_zero", {15'd0, zero_flag}, 16'd1);

        // Shift with operand select.
        load(3'd2, 8'h80);
        do_instr(4'b0011, 2'd1, 3'd1, 3'd2, 3'd6, 0, got);
        check("shr_sel1", {8'd0, got}, 16'h0040);
        do_instr(4'b0011, 2'd0, 3'd1, 3'd2, 3'd6, 0, got);
        check("shr_sel0", {8'd0, got}, 16'h0007);

        // Valid held for 10 cycles: accepts at 0, 4, 8, each adding r1 to r5.
        load(3'd5, 8'h10);
        exp_r5 = 8'h10;
        for (int k = 0; k < 3; k++) exp_r5 = exp_r5 + ref_regs[1];
        instr_valid = 1'b1;
        instr_op    = 4'b0010;
        instr_sel   = 2'd0;
        instr_rs1   = 3'd5;
        instr_rs2   = 3'd1;
        instr_rd    = 3'd5;
        for (int c = 0; c < 10; c++) begin
            if (instr_ready) acc_q.push_back(c);
            tick();
        end
        instr_valid = 1'b0;
        check("hold_accepts", 16'(acc_q.size()), 16'd3);
        if (acc_q.size() == 3) begin
            check("hold_acc0", 16'(acc_q[0]), 16'd0);
            check("hold_acc1", 16'(acc_q[1]), 16'd4);
            check("hold_acc2", 16'(acc_q[2]), 16'd8);
        end
        repeat (2) tick();
        ref_regs[5] = exp_r5;
        ref_zero    = (exp_r5 == 8'd0);
        check_reg("hold_r5", 3'd5, exp_r5);
        check("hold_ready", {15'd0, instr_ready}, 16'd1);

        // Load to rd in the WB cycle loses to the writeback.
        do_instr(4'b0001, 2'd0, 3'd1, 3'd2, 3'd7, 1, got);
        check_reg("collide_not_aa", 3'd7, 8'h8F);

        // Load to rs1 during READ: operand is the old value, file takes the new one.
        do_instr(4'b0100, 2'd0, 3'd1, 3'd2, 3'd3, 2, got);
        check_reg("ld_read_new", 3'd1, 8'h55);

        // Randomized instructions interleaved with direct loads.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) load(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            do_instr(4'($urandom_range(0, 9)), 2'($urandom_range(0, 3)),
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), got);
        end

        // Reset during EXEC aborts the instruction.
        load(3'd1, 8'h33);
        instr_valid = 1'b1;
        instr_op    = 4'b0010;
        instr_rs1   = 3'd1;
        instr_rs2   = 3'd1;
        instr_rd    = 3'd2;
        tick();
        instr_valid = 1'b0;
        tick();  // EXEC
        rst_n = 1'b0;
        #1;
        check("abort_done_now", {15'd0, done_valid}, 16'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort_done", {15'd0, done_valid}, 16'd0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort_done_rel", {15'd0, done_valid}, 16'd0);
        end
        for (int i = 0; i < 8; i++) ref_regs[i] = 8'd0;
        check("abort_ready", {15'd0, instr_ready}, 16'd1);
        check("abort_zero", {15'd0, zero_flag}, 16'd0);
        for (int i = 0; i < 8; i++) check_reg("abort_reg", 3'(i), ref_regs[i]);

        // Controller still works after the abort.
        load(3'd0, 8'h21);
        do_instr(4'b0010, 2'd0, 3'd0, 3'd0, 3'd1, 0, got);
        check("post_abort_add", {8'd0, got}, 16'h0042);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
